// File: rtl/sdram_port_arbiter_if.sv
// Avalon-MM pipelined port bundle shared by both masters and the SDRAM side.
// Master modport drives the command; slave modport answers with wait/read data.
interface sdram_port_arbiter_if #(
  parameter int AW = 22
);
  logic [AW-1:0] address;
  logic          read;
  logic          write;
  logic [15:0]   writedata;
  logic [1:0]    byteenable;
  logic          waitrequest;
  logic [15:0]   readdata;
  logic          readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Two-master Avalon-MM arbiter in front of one SDRAM controller, with a read-tag FIFO
// steering returned data. Define SDRAM_ARB_RR_EN for round-robin, else master 0 has priority.
module sdram_port_arbiter #(
  parameter int MAX_PEND = 4,
  parameter int AW       = 22
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  sdram_port_arbiter_if.slave   m0,
  sdram_port_arbiter_if.slave   m1,
  sdram_port_arbiter_if.master  s,
  output logic                  arb_error
);

  localparam int PW = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
  localparam int CW = $clog2(MAX_PEND + 1);

`ifdef SDRAM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_pending;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic          r_tag [MAX_PEND];
  logic          r_last;
  logic          r_err;

  logic          w_req0;
  logic          w_req1;
  logic          w_full;
  logic          w_granted;
  logic          w_gnt_id;
  logic          w_g_read;
  logic          w_g_write;
  logic          w_g_wait;
  logic          w_acc;
  logic          w_push;
  logic          w_pop;
  logic          w_stray;
  logic          w_head;
  logic [AW-1:0] w_s_address;
  logic [15:0]   w_s_writedata;
  logic [1:0]    w_s_byteenable;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_PEND - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_req0    = m0.read | m0.write;
  assign w_req1    = m1.read | m1.write;
  assign w_full    = (r_pending == CW'(MAX_PEND));
  assign w_granted = (r_state != IDLE);
  assign w_gnt_id  = (r_state == GRANT1);

  // Command path: the granted master is passed straight through to the controller.
  always_comb begin
    w_g_read       = w_gnt_id ? m1.read       : m0.read;
    w_g_write      = w_gnt_id ? m1.write      : m0.write;
    w_s_address    = w_gnt_id ? m1.address    : m0.address;
    w_s_writedata  = w_gnt_id ? m1.writedata  : m0.writedata;
    w_s_byteenable = w_gnt_id ? m1.byteenable : m0.byteenable;
    w_g_wait       = s.waitrequest | (w_g_read & w_full);
    w_acc          = w_granted & (w_g_read | w_g_write) & ~w_g_wait;
    w_push         = w_acc & w_g_read;
  end

  assign s.address    = w_s_address;
  assign s.writedata  = w_s_writedata;
  assign s.byteenable = w_s_byteenable;
  assign s.read       = w_granted & w_g_read & ~w_full;
  assign s.write      = w_granted & w_g_write;

  assign m0.waitrequest = (r_state == GRANT0) ? w_g_wait : 1'b1;
  assign m1.waitrequest = (r_state == GRANT1) ? w_g_wait : 1'b1;

  // Next grant; a stalled command always keeps its grant.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_req0 && w_req1)
          w_next = (RR_EN && !r_last) ? GRANT1 : GRANT0;
        else if (w_req0)
          w_next = GRANT0;
        else if (w_req1)
          w_next = GRANT1;
      end
      GRANT0: begin
        if (!w_req0)
          w_next = w_req1 ? GRANT1 : IDLE;
        else if (w_acc && w_req1 && RR_EN)
          w_next = GRANT1;
      end
      GRANT1: begin
        if (!w_req1)
          w_next = w_req0 ? GRANT0 : IDLE;
        else if (w_acc && w_req0)
          w_next = GRANT0;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_acc)
        r_last <= w_gnt_id;
    end
  end

  // Read return path: data fans out to both, only the valid is steered by the head tag.
  assign w_pop   = s.readdatavalid & (r_pending != '0);
  assign w_stray = s.readdatavalid & (r_pending == '0);
  assign w_head  = r_tag[r_rd_ptr];

  assign m0.readdata      = s.readdata;
  assign m1.readdata      = s.readdata;
  assign m0.readdatavalid = w_pop & ~w_head;
  assign m1.readdatavalid = w_pop &  w_head;
  assign arb_error        = r_err;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_pending <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_err     <= 1'b0;
      for (int i = 0; i < MAX_PEND; i++)
        r_tag[i] <= 1'b0;
    end else begin
      if (w_push) begin
        r_tag[r_wr_ptr] <= w_gnt_id;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop)
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_pending <= r_pending + 1'b1;
        2'b01:   r_pending <= r_pending - 1'b1;
        default: r_pending <= r_pending;
      endcase
      if (w_stray)
        r_err <= 1'b1;
    end
  end

endmodule
